// File: rtl/fp_accumulator.sv
// -----------------------------------------------------------------------------
// fp_accumulator
//
// Sequential BF16 accumulator that sits directly after fp_multiplier. It sums
// a vector of products, one per cycle, and presents the dot-product result
// together with sticky exception/overflow/underflow flags. The result is held
// until the consumer accepts it.
//
// Arithmetic: denormal operands are flushed to zero. The smaller operand is
// aligned using guard bits plus a sticky bit, and the sum is truncated toward
// zero. An exact zero sum gives +0. Exponent overflow saturates to signed
// infinity. Exponent underflow gives +0. Inf/NaN inputs, or an asserted
// in_exception, force the canonical quiet NaN 0x7FC0 for the rest of the
// vector.
//
// Ports:
//   clk, rst_n      single clock, synchronous active-low reset
//   in_valid/ready  product handshake (ready only while accumulating)
//   in_data         BF16 product from fp_multiplier
//   in_exception    multiplier flags that travel with in_data
//   in_overflow
//   in_underflow
//   in_last         final product of the vector
//   out_valid/ready result handshake (valid only while holding a result)
//   out_data        accumulated BF16 sum
//   out_exception   sticky flags for the vector
//   out_overflow
//   out_underflow
//   out_count       number of products summed (1..VEC_LEN)
// -----------------------------------------------------------------------------
module fp_accumulator #(
    parameter int BIT_WIDTH  = 16,
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 7,
    parameter int VEC_LEN    = 16,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] in_data,
    input  logic                 in_exception,
    input  logic                 in_overflow,
    input  logic                 in_underflow,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] out_data,
    output logic                 out_exception,
    output logic                 out_overflow,
    output logic                 out_underflow,
    output logic [CNT_WIDTH-1:0] out_count
);

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    // Significand: hidden bit + stored mantissa + guard/round/sticky bits.
    localparam int GRS_BITS = 3;
    localparam int SIG_W    = MANT_WIDTH + 1 + GRS_BITS;
    localparam int SUM_W    = SIG_W + 1;
    localparam int SH_W     = $clog2(SIG_W + 1);
    localparam int LEAD_W   = $clog2(SUM_W);
    localparam int EXP_W2   = EXP_WIDTH + 2;
    localparam int MAG_W    = BIT_WIDTH - 1;

    localparam logic [EXP_WIDTH-1:0]     EXP_MAX = '1;
    localparam logic [BIT_WIDTH-1:0]     QNAN    = {1'b0, EXP_MAX, 1'b1, {(MANT_WIDTH-1){1'b0}}};
    // The hidden bit of an unshifted operand sits at bit SUM_W-2 of the sum.
    localparam logic signed [EXP_W2-1:0] EXP_ADJ = EXP_W2'(SUM_W - 2);
    localparam logic signed [EXP_W2-1:0] EXP_OVF = EXP_W2'({2'b00, EXP_MAX});

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 state_q,    state_d;
    logic [BIT_WIDTH-1:0]   acc_q,      acc_d;
    logic [CNT_WIDTH-1:0]   cnt_q,      cnt_d;
    logic                   exc_q,      exc_d;
    logic                   ovf_q,      ovf_d;
    logic                   unf_q,      unf_d;
    logic [BIT_WIDTH-1:0]   out_data_q, out_data_d;
    logic                   out_exc_q,  out_exc_d;
    logic                   out_ovf_q,  out_ovf_d;
    logic                   out_unf_q,  out_unf_d;
    logic [CNT_WIDTH-1:0]   out_cnt_q,  out_cnt_d;

    // ------------------------------------------------------------------
    // Operand field extraction (accumulator = a, incoming product = b)
    // ------------------------------------------------------------------
    logic                 a_sign, b_sign;
    logic [EXP_WIDTH-1:0] a_exp,  b_exp;
    logic                 a_zero, b_zero;
    logic [MAG_W-1:0]     a_mag,  b_mag;
    logic [SIG_W-1:0]     a_sig,  b_sig;

    assign a_sign = acc_q[BIT_WIDTH-1];
    assign b_sign = in_data[BIT_WIDTH-1];
    assign a_exp  = acc_q[BIT_WIDTH-2 -: EXP_WIDTH];
    assign b_exp  = in_data[BIT_WIDTH-2 -: EXP_WIDTH];
    assign a_zero = (a_exp == '0);
    assign b_zero = (b_exp == '0);
    // Flushed magnitudes, so a denormal never wins the ordering compare.
    assign a_mag  = a_zero ? '0 : acc_q[MAG_W-1:0];
    assign b_mag  = b_zero ? '0 : in_data[MAG_W-1:0];
    assign a_sig  = a_zero ? '0 : {1'b1, acc_q[MANT_WIDTH-1:0], {GRS_BITS{1'b0}}};
    assign b_sig  = b_zero ? '0 : {1'b1, in_data[MANT_WIDTH-1:0], {GRS_BITS{1'b0}}};

    // ------------------------------------------------------------------
    // Single-cycle adder: align, add/subtract, normalise, truncate
    // ------------------------------------------------------------------
    logic                     big_sign, small_sign;
    logic [EXP_WIDTH-1:0]     big_exp,  small_exp, exp_diff;
    logic [SIG_W-1:0]         big_sig,  small_sig, aligned;
    logic [SH_W-1:0]          shamt;
    logic [2*SIG_W-1:0]       shift_wide;
    logic [SUM_W-1:0]         sum, norm;
    logic [LEAD_W-1:0]        lead;
    logic signed [EXP_W2-1:0] res_exp;
    logic [MANT_WIDTH-1:0]    res_mant;
    logic [BIT_WIDTH-1:0]     add_res;
    logic                     add_ovf, add_unf;

    // NOTE: every variable written in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        big_sign   = a_sign;
        big_exp    = a_exp;
        big_sig    = a_sig;
        small_sign = b_sign;
        small_exp  = b_exp;
        small_sig  = b_sig;
        add_res    = '0;
        add_ovf    = 1'b0;
        add_unf    = 1'b0;
        lead       = '0;

        // Larger magnitude first; this makes the difference non-negative.
        if (b_mag > a_mag) begin
            big_sign   = b_sign;
            big_exp    = b_exp;
            big_sig    = b_sig;
            small_sign = a_sign;
            small_exp  = a_exp;
            small_sig  = a_sig;
        end

        // Shifts of SIG_W or more leave only the sticky bit.
        exp_diff   = big_exp - small_exp;
        shamt      = (exp_diff > EXP_WIDTH'(SIG_W)) ? SH_W'(SIG_W) : exp_diff[SH_W-1:0];
        shift_wide = {small_sig, {SIG_W{1'b0}}} >> shamt;
        // Bits shifted out fold into the LSB. A subtraction then borrows
        // correctly, so truncation lands below the exact result.
        aligned    = shift_wide[2*SIG_W-1:SIG_W]
                   | {{(SIG_W-1){1'b0}}, |shift_wide[SIG_W-1:0]};

        if (big_sign == small_sign) begin
            sum = {1'b0, big_sig} + {1'b0, aligned};
        end else begin
            sum = {1'b0, big_sig} - {1'b0, aligned};
        end

        for (int i = 0; i < SUM_W; i++) begin
            if (sum[i]) begin
                lead = LEAD_W'(i);
            end
        end

        norm     = sum << (LEAD_W'(SUM_W - 1) - lead);
        res_mant = MANT_WIDTH'(norm >> (SUM_W - 1 - MANT_WIDTH));
        res_exp  = $signed({2'b00, big_exp})
                 + $signed({{(EXP_W2-LEAD_W){1'b0}}, lead})
                 - EXP_ADJ;

        if (sum == '0) begin
            add_res = '0;
        end else if (res_exp >= EXP_OVF) begin
            add_res = {big_sign, EXP_MAX, {MANT_WIDTH{1'b0}}};
            add_ovf = 1'b1;
        end else if (res_exp <= 0) begin
            add_res = '0;
            add_unf = 1'b1;
        end else begin
            add_res = {big_sign, res_exp[EXP_WIDTH-1:0], res_mant};
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        exc_d      = exc_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        out_data_d = out_data_q;
        out_exc_d  = out_exc_q;
        out_ovf_d  = out_ovf_q;
        out_unf_d  = out_unf_q;
        out_cnt_d  = out_cnt_q;

        case (state_q)
            ST_ACC: begin
                // in_ready is high throughout ACC, so in_valid alone is an accept.
                if (in_valid) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                    if (exc_q || in_exception || (b_exp == EXP_MAX)) begin
                        acc_d = QNAN;
                        exc_d = 1'b1;
                    end else if (a_exp == EXP_MAX) begin
                        // Without exc_q, an all-ones accumulator exponent can
                        // only be a saturated infinity. It absorbs finite inputs.
                        acc_d = acc_q;
                    end else begin
                        acc_d = add_res;
                        ovf_d = ovf_q | add_ovf;
                        unf_d = unf_q | add_unf;
                    end
                    ovf_d = ovf_d | in_overflow;
                    unf_d = unf_d | in_underflow;

                    if (in_last || (cnt_d == CNT_WIDTH'(VEC_LEN))) begin
                        out_data_d = acc_d;
                        out_exc_d  = exc_d;
                        out_ovf_d  = ovf_d;
                        out_unf_d  = unf_d;
                        out_cnt_d  = cnt_d;
                        state_d    = ST_OUT;
                    end
                end
            end

            ST_OUT: begin
                if (out_ready) begin
                    state_d    = ST_ACC;
                    acc_d      = '0;
                    cnt_d      = '0;
                    exc_d      = 1'b0;
                    ovf_d      = 1'b0;
                    unf_d      = 1'b0;
                    out_data_d = '0;
                    out_exc_d  = 1'b0;
                    out_ovf_d  = 1'b0;
                    out_unf_d  = 1'b0;
                    out_cnt_d  = '0;
                end
            end

            default: state_d = ST_ACC;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: reset is synchronous, so it sits inside the clocked branch and is
    // not in the sensitivity list; a mid-vector reset drops the partial sum.
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples its _d value from before the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_ACC;
            acc_q      <= '0;
            cnt_q      <= '0;
            exc_q      <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            out_data_q <= '0;
            out_exc_q  <= 1'b0;
            out_ovf_q  <= 1'b0;
            out_unf_q  <= 1'b0;
            out_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            exc_q      <= exc_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            out_data_q <= out_data_d;
            out_exc_q  <= out_exc_d;
            out_ovf_q  <= out_ovf_d;
            out_unf_q  <= out_unf_d;
            out_cnt_q  <= out_cnt_d;
        end
    end

    assign in_ready      = (state_q == ST_ACC);
    assign out_valid     = (state_q == ST_OUT);
    assign out_data      = out_data_q;
    assign out_exception = out_exc_q;
    assign out_overflow  = out_ovf_q;
    assign out_underflow = out_unf_q;
    assign out_count     = out_cnt_q;

endmodule

// File: tb/tb_fp_accumulator.sv
// -----------------------------------------------------------------------------
// tb_fp_accumulator
//
// Directed bench for fp_accumulator with VEC_LEN=4. A table of vectors is
// applied, each with a hand-computed BF16 result, flags and count. Short
// hand-written sequences cover reset state, result latency, holding the
// result while out_ready is low, and reset in the middle of a vector.
// -----------------------------------------------------------------------------
module tb_fp_accumulator;

    localparam int VL = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   in_data;
    logic          in_exception;
    logic          in_overflow;
    logic          in_underflow;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_data;
    logic          out_exception;
    logic          out_overflow;
    logic          out_underflow;
    logic [CW-1:0] out_count;

    int n_pass  = 0;
    int n_total = 0;

    fp_accumulator #(
        .BIT_WIDTH (16),
        .EXP_WIDTH (8),
        .MANT_WIDTH(7),
        .VEC_LEN   (VL),
        .CNT_WIDTH (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_exception (in_exception),
        .in_overflow  (in_overflow),
        .in_underflow (in_underflow),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_exception(out_exception),
        .out_overflow (out_overflow),
        .out_underflow(out_underflow),
        .out_count    (out_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        string          name;
        int             n;
        logic [3:0][15:0] d;
        logic [3:0]     ex;
        logic [3:0]     ov;
        logic [3:0]     un;
        logic           use_last;
        logic [15:0]    e_data;
        logic           e_exc;
        logic           e_ovf;
        logic           e_unf;
        int             e_cnt;
    } vec_t;

    function automatic vec_t mk(input string name, input int n,
                                input logic [15:0] d0, input logic [15:0] d1,
                                input logic [15:0] d2, input logic [15:0] d3,
                                input logic [3:0] ex, input logic [3:0] ov,
                                input logic [3:0] un, input logic use_last,
                                input logic [15:0] e_data, input logic e_exc,
                                input logic e_ovf, input logic e_unf,
                                input int e_cnt);
        vec_t v;
        v.name     = name;
        v.n        = n;
        v.d[0]     = d0;
        v.d[1]     = d1;
        v.d[2]     = d2;
        v.d[3]     = d3;
        v.ex       = ex;
        v.ov       = ov;
        v.un       = un;
        v.use_last = use_last;
        v.e_data   = e_data;
        v.e_exc    = e_exc;
        v.e_ovf    = e_ovf;
        v.e_unf    = e_unf;
        v.e_cnt    = e_cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Present one product at the negedge and wait for it to be accepted.
    // in_valid stays high afterwards, so back-to-back calls stream products.
    task automatic put(input logic [15:0] d, input logic ex, input logic ov,
                       input logic un, input logic last);
        in_valid     = 1'b1;
        in_data      = d;
        in_exception = ex;
        in_overflow  = ov;
        in_underflow = un;
        in_last      = last;
        for (int k = 0; k < 20 && !in_ready; k++) @(negedge clk);
        check("in_ready_wait", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drop_valid();
        in_valid     = 1'b0;
        in_last      = 1'b0;
        in_exception = 1'b0;
        in_overflow  = 1'b0;
        in_underflow = 1'b0;
    endtask

    // Wait for the result, compare it, then complete the output handshake.
    task automatic get_out(input string name, input logic [15:0] e_data,
                           input logic e_exc, input logic e_ovf,
                           input logic e_unf, input int e_cnt);
        for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
        check({name, ".out_valid"}, {31'b0, out_valid}, 32'd1);
        check({name, ".data"},      {16'b0, out_data}, {16'b0, e_data});
        check({name, ".exc"},       {31'b0, out_exception}, {31'b0, e_exc});
        check({name, ".ovf"},       {31'b0, out_overflow},  {31'b0, e_ovf});
        check({name, ".unf"},       {31'b0, out_underflow}, {31'b0, e_unf});
        check({name, ".count"},     {29'b0, out_count}, e_cnt);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({name, ".ready_after_dump"}, {31'b0, in_ready}, 32'd1);
    endtask

    vec_t tbl[$];

    initial begin
        // Each row: name, n, d0..d3, ex, ov, un, use_last,
        //           expected data, exc, ovf, unf, count.
        tbl.push_back(mk("cancel",    2, 16'h3F80, 16'hBF80, 16'h0, 16'h0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 2));
        tbl.push_back(mk("ovf_sat",   3, 16'h7F7F, 16'h7F7F, 16'hFF7F, 16'h0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 16'h7F80, 1'b0, 1'b1, 1'b0, 3));
        tbl.push_back(mk("vec_len",   4, 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 4'b0000, 4'b0000, 4'b0000, 1'b0, 16'h4080, 1'b0, 1'b0, 1'b0, 4));
        tbl.push_back(mk("exc_in",    2, 16'h4000, 16'h3F80, 16'h0, 16'h0, 4'b0001, 4'b0000, 4'b0000, 1'b1, 16'h7FC0, 1'b1, 1'b0, 1'b0, 2));
        tbl.push_back(mk("inf_in",    2, 16'h3F80, 16'h7F80, 16'h0, 16'h0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 16'h7FC0, 1'b1, 1'b0, 1'b0, 2));
        tbl.push_back(mk("underflow", 2, 16'h0100, 16'h80C0, 16'h0, 16'h0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 2));
        tbl.push_back(mk("flush",     2, 16'h3F80, 16'h0001, 16'h0, 16'h0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 16'h3F80, 1'b0, 1'b0, 1'b0, 2));
        tbl.push_back(mk("trunc_add", 2, 16'h3F80, 16'h3B80, 16'h0, 16'h0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 16'h3F80, 1'b0, 1'b0, 1'b0, 2));
        tbl.push_back(mk("trunc_sub", 2, 16'h3F80, 16'hBB80, 16'h0, 16'h0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 16'h3F7F, 1'b0, 1'b0, 1'b0, 2));
        tbl.push_back(mk("sticky",    2, 16'h3F80, 16'hB380, 16'h0, 16'h0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 16'h3F7F, 1'b0, 1'b0, 1'b0, 2));
        tbl.push_back(mk("flag_pass", 1, 16'h3F80, 16'h0, 16'h0, 16'h0, 4'b0000, 4'b0001, 4'b0001, 1'b1, 16'h3F80, 1'b0, 1'b1, 1'b1, 1));

        rst_n     = 1'b0;
        out_ready = 1'b0;
        in_data   = 16'h0;
        drop_valid();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.in_ready",  {31'b0, in_ready},  32'd1);
        check("rst.out_valid", {31'b0, out_valid}, 32'd0);
        check("rst.out_data",  {16'b0, out_data},  32'h0);
        check("rst.flags",     {29'b0, out_exception, out_overflow, out_underflow}, 32'd0);
        check("rst.count",     {29'b0, out_count}, 32'd0);

        // 1.0 + 2.0 + 0.5 with in_valid held high; result one cycle after last accept
        put(16'h3F80, 1'b0, 1'b0, 1'b0, 1'b0);
        put(16'h4000, 1'b0, 1'b0, 1'b0, 1'b0);
        check("sum3.no_early_valid", {31'b0, out_valid}, 32'd0);
        put(16'h3F00, 1'b0, 1'b0, 1'b0, 1'b1);
        drop_valid();
        check("sum3.latency", {31'b0, out_valid}, 32'd1);
        get_out("sum3", 16'h4060, 1'b0, 1'b0, 1'b0, 3);

        // Table-driven vectors
        for (int v = 0; v < tbl.size(); v++) begin
            vec_t cur;
            cur = tbl[v];
            for (int i = 0; i < cur.n; i++) begin
                put(cur.d[i], cur.ex[i], cur.ov[i], cur.un[i],
                    cur.use_last && (i == cur.n - 1));
            end
            drop_valid();
            get_out(cur.name, cur.e_data, cur.e_exc, cur.e_ovf, cur.e_unf, cur.e_cnt);
        end

        // Hold the overflowed result while out_ready is low; in_valid pulses must be ignored
        put(16'h7F7F, 1'b0, 1'b0, 1'b0, 1'b0);
        put(16'h7F7F, 1'b0, 1'b0, 1'b0, 1'b1);
        drop_valid();
        for (int k = 0; k < 3; k++) begin
            in_valid = (k != 1);
            in_data  = 16'h3F80;
            in_last  = 1'b1;
            check("hold.out_data",  {16'b0, out_data},  32'h7F80);
            check("hold.in_ready",  {31'b0, in_ready},  32'd0);
            check("hold.out_valid", {31'b0, out_valid}, 32'd1);
            @(posedge clk);
            @(negedge clk);
        end
        drop_valid();
        get_out("hold", 16'h7F80, 1'b0, 1'b1, 1'b0, 2);
        put(16'h4040, 1'b0, 1'b0, 1'b0, 1'b1);
        drop_valid();
        get_out("after_hold", 16'h4040, 1'b0, 1'b0, 1'b0, 1);

        // Reset in the middle of a vector discards the partial sum
        put(16'h3F80, 1'b0, 1'b0, 1'b0, 1'b0);
        put(16'h4000, 1'b0, 1'b0, 1'b0, 1'b0);
        drop_valid();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst.in_ready",  {31'b0, in_ready},  32'd1);
        check("midrst.out_valid", {31'b0, out_valid}, 32'd0);
        put(16'h3F80, 1'b0, 1'b0, 1'b0, 1'b1);
        drop_valid();
        get_out("midrst", 16'h3F80, 1'b0, 1'b0, 1'b0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
